// File: rtl/led_arbiter.sv
// led_arbiter: round-robin arbiter that lets one of N_REQ requesters drive an LED
// controller, waits for the controller to echo the pattern back, then acks or times out.
// Ports:
//   clk, rst_i                 : clock, asynchronous active-high reset
//   req_i, data_i              : per-requester request level and LED pattern
//   ack_o, err_o               : one-cycle completion / timeout pulse to the owner
//   busy_o, grant_o            : FSM not idle; index of current or last owner
//   led_en_o, led_data_o       : one-cycle enable and held pattern to the LED controller
//   led_cb_i                   : pattern echoed back by the LED controller
module led_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MIN_WAIT   = 3,
    parameter int TIMEOUT    = 16,
    localparam int GW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] data_i,
    output logic [N_REQ-1:0]            ack_o,
    output logic [N_REQ-1:0]            err_o,
    output logic                        busy_o,
    output logic [GW-1:0]               grant_o,
    output logic                        led_en_o,
    output logic [DATA_WIDTH-1:0]       led_data_o,
    input  logic [DATA_WIDTH-1:0]       led_cb_i
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] MIN_C = CW'(MIN_WAIT);
    localparam logic [CW-1:0] TO_C  = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [GW-1:0]           rr_r, rr_n;
    logic [GW-1:0]           grant_n;
    logic [DATA_WIDTH-1:0]   led_data_n;
    logic                    led_en_n;
    logic                    busy_n;
    logic [N_REQ-1:0]        ack_n, err_n;

    logic                    found;
    logic [GW-1:0]           winner;

    // Round-robin search: first set request at or above rr_r, wrapping to 0.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_r) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req_i[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        rr_n       = rr_r;
        grant_n    = grant_o;
        led_data_n = led_data_o;
        led_en_n   = 1'b0;
        ack_n      = '0;
        err_n      = '0;

        case (state)
            IDLE: begin
                if (found) begin
                    state_n    = ISSUE;
                    grant_n    = winner;
                    led_data_n = data_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                    led_en_n   = 1'b1;
                end
            end
            ISSUE: begin
                state_n = WAIT;
                cnt_n   = '0;
            end
            WAIT: begin
                // Early matches are ignored so a cleared callback cannot
                // falsely acknowledge an all-zero pattern. A match on the
                // final counted cycle still beats the timeout.
                if (cnt >= MIN_C && led_cb_i == led_data_o) begin
                    state_n        = DONE;
                    ack_n[grant_o] = 1'b1;
                end else if (cnt == TO_C) begin
                    state_n        = DONE;
                    err_n[grant_o] = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                rr_n    = (grant_o == GW'(N_REQ - 1)) ? '0 : grant_o + 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            rr_r       <= '0;
            grant_o    <= '0;
            led_data_o <= '0;
            led_en_o   <= 1'b0;
            ack_o      <= '0;
            err_o      <= '0;
            busy_o     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            rr_r       <= rr_n;
            grant_o    <= grant_n;
            led_data_o <= led_data_n;
            led_en_o   <= led_en_n;
            ack_o      <= ack_n;
            err_o      <= err_n;
            busy_o     <= busy_n;
        end
    end

endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): N_REQ, 4, number of requesters.
REQ-002 SHALL have parameter DATA_WIDTH, 8, LED pattern width.
REQ-003 SHALL have parameter MIN_WAIT, 3, WAIT cycles before the callback is compared.
REQ-004 SHALL have parameter TIMEOUT, 16, WAIT cycles before a transaction is failed (TIMEOUT > MIN_WAIT).
REQ-005 SHALL have ports (name, direction, width, meaning): clk, in, 1, single clock, all logic on rising edge.
REQ-006 SHALL have rst_i, in, 1, reset; asynchronous, active-high.
REQ-007 SHALL have req_i, in, N_REQ, per-requester request level.
REQ-008 SHALL have data_i, in, N_REQ*DATA_WIDTH, requester k pattern in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have ack_o, out, N_REQ, one-cycle pulse on successful completion.
REQ-010 SHALL have err_o, out, N_REQ, one-cycle pulse on timeout.
REQ-011 SHALL have busy_o, out, 1, high in every state except IDLE.
REQ-012 SHALL have grant_o, out, clog2(N_REQ), index of the current or last owner.
REQ-013 SHALL have led_en_o, out, 1, to the LED controller enable.
REQ-014 SHALL have led_data_o, out, DATA_WIDTH, to the LED controller data.
REQ-015 SHALL have led_cb_i, in, DATA_WIDTH, LED controller callback (echoes the held pattern).

Function
REQ-016 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-017 IDLE: stay while req_i==0; otherwise select the winner and go to ISSUE at the next edge.
REQ-018 Arbitration SHALL be round-robin: the winner is the first set req_i bit searching upward from pointer rr_r, wrapping N_REQ-1 to 0.
REQ-019 On IDLE->ISSUE, the block SHALL latch grant_o=winner and led_data_o=data_i[winner], and set led_en_o=1.
REQ-020 ISSUE SHALL last exactly one cycle (led_en_o high exactly one cycle), then go to WAIT with counter cnt=0.
REQ-021 In WAIT, cnt SHALL increment by 1 per cycle, saturating at TIMEOUT.
REQ-022 In WAIT, when cnt>=MIN_WAIT and led_cb_i==led_data_o, the block SHALL go to DONE with status OK.
REQ-023 A match with cnt<MIN_WAIT SHALL be ignored; this makes pattern 0 safe against the controller's cleared callback.
REQ-024 In WAIT, when cnt==TIMEOUT without a qualifying match, the block SHALL go to DONE with status ERR.
REQ-025 If a match and cnt==TIMEOUT occur in the same cycle, the match SHALL win and the status SHALL be OK.
REQ-026 DONE SHALL last one cycle: pulse ack_o[grant_o] (OK) or err_o[grant_o] (ERR), set rr_r=(grant_o+1) mod N_REQ, then return to IDLE.
REQ-027 At most one bit of ack_o|err_o SHALL be set in any cycle.
REQ-028 Once latched, a transaction SHALL complete regardless of req_i or data_i changes.
REQ-029 If the owner drops req_i mid-transaction, its ack_o/err_o pulse SHALL still be issued.
REQ-030 Requesters SHALL hold req_i until ack/err. A request still high in the IDLE cycle after DONE SHALL be re-arbitrated as a new transaction.
REQ-031 led_data_o and grant_o SHALL hold their value after DONE until the next ISSUE.
REQ-032 Minimum transaction length SHALL be IDLE->ISSUE->WAIT(MIN_WAIT+1 cycles)->DONE, i.e. ack 6 cycles after req with defaults.

Reset
REQ-033 Asserting rst_i SHALL immediately force: state=IDLE, rr_r=0, cnt=0, grant_o=0, led_data_o=0, led_en_o=0, ack_o=0, err_o=0, busy_o=0.
REQ-034 Reset mid-transaction SHALL abort the transaction with no ack/err pulse.
REQ-035 After rst_i deasserts, arbitration SHALL restart from requester 0.

Verification
REQ-036 Single request: req_i=0001, data 0xA5, echo model -> one led_en_o pulse, led_data_o=0xA5, ack_o=0001 once, err_o=0.
REQ-037 Round-robin: req_i=1111 held, ack each -> grants in order 0,1,2,3,0; no requester served twice before others.
REQ-038 Zero pattern: data 0x00, led_cb_i=0x00 throughout -> ack only at cnt==MIN_WAIT, never earlier.
REQ-039 Timeout: led_cb_i stuck at 0x11, data 0x22 -> err_o pulse after TIMEOUT WAIT cycles, ack_o=0, rr_r advances.
REQ-040 Boundary: match on exactly cnt==TIMEOUT -> ack_o pulses and err_o=0.
REQ-041 Reset mid-WAIT: rst_i pulsed -> all outputs 0 immediately, no ack/err, next grant goes to the lowest set req_i from 0.
